// File: rtl/hwpe_stream_tcdm_load_buffer_pkg.sv
// Shared types for the TCDM load buffer: the flags struct exported to
// the controller and a helper for the FIFO counter width.
package hwpe_stream_package;

    // Width of the occupancy field in the flags struct. It is fixed so the
    // struct stays a plain packed type; buffers deeper than 255 entries are
    // not expected.
    localparam int unsigned FLAGS_COUNT_W = 8;

    typedef struct packed {
        logic [FLAGS_COUNT_W-1:0] fifo_count;
        logic                     outstanding;
        logic                     empty;
        logic                     full;
        logic                     wr_err;
    } flags_tcdm_load_buffer_t;

    // Counter must represent 0..depth inclusive.
    function automatic int unsigned fifo_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_load_buffer_if.sv
// TCDM request/response port bundle. wen=1 is a load, wen=0 a store.
interface hwpe_stream_intf_tcdm #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                    req;
    logic                    gnt;
    logic [31:0]             add;
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hwpe_stream_tcdm_load_buffer_fifo.sv
// Response storage for the load buffer: circular buffer with registered
// count, synchronous active-high reset and clear. A push on a full buffer
// is only accepted together with a pop; a pop on empty is ignored.
module hwpe_stream_load_buffer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array: data is qualified by the count, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; push+pop together keeps the count.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// Load buffer between a stream source and the TCDM interconnect. Loads are
// forwarded only while a response slot is guaranteed (outstanding + stored
// < FIFO_DEPTH), so the consumer may stall without losing responses.
// Optional macro HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN lets a response
// bypass the empty buffer when the consumer is ready.
module hwpe_stream_tcdm_load_buffer
    import hwpe_stream_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    hwpe_stream_intf_tcdm.slave     tcdm_slave,
    hwpe_stream_intf_tcdm.master    tcdm_master,
    input  logic                    ready_i,
    output flags_tcdm_load_buffer_t flags_o
);

    localparam int unsigned CNT_W = fifo_count_width(FIFO_DEPTH);

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W:0]        occupancy;
    logic                  credit, load_req, resp_valid, bypass;
    logic                  outstanding_q, wr_err_q, drop_q;
    logic                  unused_slave_data;

    // Credit uses registered state only, so ready_i never reaches master req.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding_q};
    assign credit    = (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    // Stores are never forwarded; they only raise the error flag.
    assign load_req = tcdm_slave.req & tcdm_slave.wen;

    assign tcdm_master.req  = load_req & credit & ~rst_i & ~clear_i;
    assign tcdm_master.add  = tcdm_slave.add;
    assign tcdm_master.be   = tcdm_slave.be;
    assign tcdm_master.wen  = 1'b1;
    assign tcdm_master.data = '0;
    assign tcdm_slave.gnt   = tcdm_master.req & tcdm_master.gnt;

    assign unused_slave_data = ^tcdm_slave.data;

    // Responses in a reset/clear cycle, or the one right after, belong to
    // requests that were flushed and are discarded.
    assign resp_valid = tcdm_master.r_valid & ~drop_q & ~rst_i & ~clear_i;

`ifdef HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN
    assign bypass             = fifo_empty & ready_i & resp_valid;
    assign tcdm_slave.r_valid = fifo_empty ? (ready_i & resp_valid) : 1'b1;
    assign tcdm_slave.r_data  = fifo_empty ? tcdm_master.r_data : fifo_head;
`else
    assign bypass             = 1'b0;
    assign tcdm_slave.r_valid = ~fifo_empty;
    assign tcdm_slave.r_data  = fifo_head;
`endif

    assign fifo_push = resp_valid & ~bypass;
    assign fifo_pop  = ~fifo_empty & ready_i;

    hwpe_stream_load_buffer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (fifo_push),
        .data_i  (tcdm_master.r_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Outstanding request tracking, sticky store error, late-response drop.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            outstanding_q <= 1'b0;
            wr_err_q      <= 1'b0;
            drop_q        <= 1'b1;
        end else begin
            drop_q <= 1'b0;
            if (tcdm_master.req && tcdm_master.gnt) begin
                outstanding_q <= 1'b1;
            end else if (tcdm_master.r_valid) begin
                outstanding_q <= 1'b0;
            end
            if (tcdm_slave.req && !tcdm_slave.wen) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    // Flags are decoded purely from registered state.
    always_comb begin
        flags_o             = '0;
        flags_o.fifo_count  = FLAGS_COUNT_W'(fifo_count);
        flags_o.outstanding = outstanding_q;
        flags_o.empty       = fifo_empty;
        flags_o.full        = fifo_full;
        flags_o.wr_err      = wr_err_q;
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_buffer.sv
// Bench for hwpe_stream_tcdm_load_buffer: a TCDM memory model answering one
// cycle after grant with data = address, a queue scoreboard of accepted
// loads, and directed plus random phases.
module tb_hwpe_stream_tcdm_load_buffer;
    import hwpe_stream_package::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
`ifdef HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic ready = 1'b0;
    flags_tcdm_load_buffer_t flags;

    hwpe_stream_intf_tcdm #(.DATA_WIDTH(DW)) s_if ();
    hwpe_stream_intf_tcdm #(.DATA_WIDTH(DW)) m_if ();

    hwpe_stream_tcdm_load_buffer #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .tcdm_slave  (s_if),
        .tcdm_master (m_if),
        .ready_i     (ready),
        .flags_o     (flags)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_gnt   = 0;
    int n_resp  = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [31:0] add;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // TCDM memory: fixed one-cycle latency, returns the address as data.
    initial begin
        logic        g;
        logic [31:0] a;
        m_if.r_valid = 1'b0;
        m_if.r_data  = '0;
        forever begin
            @(negedge clk);
            g = m_if.req & m_if.gnt;
            a = m_if.add;
            @(posedge clk);
            #1;
            m_if.r_valid = g;
            m_if.r_data  = a;
        end
    end

    // Monitor: consume responses against the scoreboard, record accepted loads.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (s_if.r_valid && ready) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", s_if.r_data, e.add);
                    if (lat_chk) chk("resp_latency", cyc - e.cyc, LAT);
                end
            end
            if (m_if.r_valid) chk("no_overflow", flags.full, 0);
            chk("count_le_depth", flags.fifo_count > DEPTH, 0);
            if (clear) exp_q.delete();
            if (s_if.req && s_if.gnt) begin
                n_gnt++;
                exp_q.push_back('{s_if.add, cyc});
            end
        end
    end

    initial begin
        flags_tcdm_load_buffer_t r_exp;
        int g0, r0, k;
        r_exp = '{fifo_count: '0, outstanding: 1'b0, empty: 1'b1, full: 1'b0, wr_err: 1'b0};
        s_if.req = 1'b1; s_if.wen = 1'b1; s_if.add = '0; s_if.be = '1; s_if.data = '0;
        m_if.gnt = 1'b1;

        // Reset state, with a load pending at the slave.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", flags, r_exp);
        chk("reset_slave_rvalid", s_if.r_valid, 0);
        chk("reset_master_req", m_if.req, 0);
        chk("reset_slave_gnt", s_if.gnt, 0);
        @(posedge clk); #1;
        rst = 1'b0; s_if.req = 1'b0;

        // 8 back-to-back loads, latency and order checked by the monitor.
        ready = 1'b1; lat_chk = 1'b1; g0 = n_gnt; r0 = n_resp;
        s_if.req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_if.add = 32'h1000 + 32'(i * 4);
            @(posedge clk); #1;
        end
        s_if.req = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("p1_grants", n_gnt - g0, 8);
        chk("p1_resps", n_resp - r0, 8);
        lat_chk = 1'b0;

        // Consumer stalled: exactly DEPTH grants, then one pop frees one slot.
        ready = 1'b0; g0 = n_gnt; s_if.req = 1'b1; s_if.add = 32'h2000;
        repeat (10) begin
            @(posedge clk); #1;
            s_if.add = s_if.add + 32'd4;
        end
        chk("p2_grants", n_gnt - g0, 4);
        chk("p2_full", flags.full, 1);
        chk("p2_gnt_blocked", s_if.gnt, 0);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        chk("p2_count_after_pop", flags.fifo_count, 3);
        chk("p2_regrant", s_if.gnt, 1);
        @(posedge clk); #1;
        chk("p2_regrant_once", s_if.gnt, 0);
        chk("p2_total_grants", n_gnt - g0, 5);
        @(posedge clk); #1;
        chk("p2_full_again", flags.full, 1);
        s_if.req = 1'b0; ready = 1'b1;
        repeat (8) @(posedge clk); #1;

        // Random grant/ready, 1000 loads.
        g0 = n_gnt; s_if.req = 1'b1;
        for (int c = 0; c < 20000 && (n_gnt - g0) < 1000; c++) begin
            s_if.add = $urandom;
            m_if.gnt = 1'($urandom_range(0, 1));
            ready    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        s_if.req = 1'b0; m_if.gnt = 1'b1; ready = 1'b1;
        chk("p3_grants", n_gnt - g0, 1000);
        repeat (10) @(posedge clk); #1;
        chk("p3_drained_empty", flags.empty, 1);

        // Clear with 3 entries stored and a response in flight.
        ready = 1'b0; s_if.req = 1'b1; s_if.add = 32'h3000; k = 0;
        while (flags.fifo_count != 3 && k < 20) begin
            @(posedge clk); #1;
            s_if.add = s_if.add + 32'd4;
            k++;
        end
        chk("clr_setup", flags.fifo_count, 3);
        clear = 1'b1;
        @(negedge clk);
        chk("clr_master_req", m_if.req, 0);
        chk("clr_slave_gnt", s_if.gnt, 0);
        @(posedge clk); #1;
        clear = 1'b0; s_if.req = 1'b0;
        chk("clr_rvalid", s_if.r_valid, 0);
        chk("clr_count", flags.fifo_count, 0);
        chk("clr_empty", flags.empty, 1);
        chk("clr_outstanding", flags.outstanding, 0);
        @(posedge clk); #1;
        chk("clr_late_dropped", flags.fifo_count, 0);
        ready = 1'b1; s_if.req = 1'b1; s_if.add = 32'h3800;
        repeat (6) begin
            @(posedge clk); #1;
            s_if.add = s_if.add + 32'd4;
        end
        s_if.req = 1'b0;
        repeat (5) @(posedge clk); #1;

        // Store request: not forwarded, sticky error until clear.
        g0 = n_gnt;
        s_if.req = 1'b1; s_if.wen = 1'b0; s_if.add = 32'h4000;
        @(negedge clk);
        chk("wr_master_req", m_if.req, 0);
        chk("wr_slave_gnt", s_if.gnt, 0);
        @(posedge clk); #1;
        s_if.req = 1'b0; s_if.wen = 1'b1;
        chk("wr_err_set", flags.wr_err, 1);
        repeat (3) @(posedge clk); #1;
        chk("wr_err_sticky", flags.wr_err, 1);
        chk("wr_no_grant", n_gnt - g0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("wr_err_cleared", flags.wr_err, 0);

        repeat (5) @(posedge clk); #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_tcdm_load_buffer.md
HWPE_STREAM_TCDM_LOAD_BUFFER -- requirements
Module: hwpe_stream_tcdm_load_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, response-buffer entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, TCDM word width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear_i  input  1  synchronous flush.
REQ-006 SHALL have port tcdm_slave  hwpe_stream_intf_tcdm.slave  DATA_WIDTH  load port from the upstream stream source.
REQ-007 SHALL have port tcdm_master  hwpe_stream_intf_tcdm.master  DATA_WIDTH  load port to TCDM interconnect.
REQ-008 SHALL have port ready_i  input  1  consumer accepts the current slave-side response (wired to the source's tcdm_fifo_ready_o).
REQ-009 SHALL have port flags_o  output  flags_tcdm_load_buffer_t  occupancy, outstanding, sticky write error.

Function
REQ-010 SHALL forward req/add/be combinationally slave->master only while credit is available: outstanding + fifo_count < FIFO_DEPTH, using registered values only. There SHALL be no combinational path from ready_i to master req.
REQ-011 SHALL drive slave gnt = master gnt & credit. Otherwise slave gnt = 0 and master req = 0.
REQ-012 SHALL assume fixed TCDM latency: master r_valid exactly 1 cycle after a granted request. The outstanding register (0/1) SHALL set on master req&gnt and clear on master r_valid.
REQ-013 SHALL push every master r_data with r_valid into the FIFO. An overflowing push is impossible by REQ-010; the bench SHALL assert this.
REQ-014 SHALL drive slave r_valid = FIFO not-empty and slave r_data = FIFO head. It SHALL pop on r_valid & ready_i.
REQ-015 Simultaneous push and pop SHALL leave the count unchanged and keep order. Pop SHALL free credit from the next cycle only.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH. Count width SHALL be $clog2(FIFO_DEPTH+1).
REQ-017 A slave request with wen=0 SHALL NOT be forwarded: gnt=0, flags_o.wr_err set sticky until reset/clear. master wen SHALL be tied 1, master data '0.
REQ-018 Responses SHALL be delivered strictly in request order, no loss, no duplication.
REQ-019 flags_o SHALL carry fifo_count, outstanding, empty, full, wr_err; all registered.

Reset
REQ-020 On rst_i=1: FIFO pointers and count 0, outstanding 0, wr_err 0, slave r_valid 0, master req 0, flags_o all 0 except empty=1.
REQ-021 clear_i SHALL have identical effect to reset, and SHALL also drop the master r_valid arriving in the cycle after clear for a request granted in the clear cycle.
REQ-022 While clear_i=1, master req SHALL be 0.

Configuration
REQ-023 With HWPE_STREAM_LOAD_BUFFER_FALLTHROUGH_EN defined: when FIFO empty and ready_i=1, master r_valid/r_data SHALL pass combinationally to slave r_valid/r_data without a push. Response latency is then 1 cycle after gnt.
REQ-024 Without the macro: all responses pass through the FIFO. Response latency is 2 cycles after gnt, with ready_i=1.

Structure
REQ-025 flags_tcdm_load_buffer_t SHALL be declared in hwpe_stream_package.
REQ-026 Storage SHALL be one sub-module hwpe_stream_load_buffer_fifo (push/pop/count, sync active-high reset and clear). Credit and outstanding logic SHALL stay in the top module.

Verification
REQ-027 Reset then 8 back-to-back loads, ready_i=1, gnt=1 -> 8 responses in order, data = address tag, no bubbles after first; latency 2 (1 with FALLTHROUGH_EN).
REQ-028 FIFO_DEPTH=4, ready_i=0, slave req held -> exactly 4 grants then gnt=0, full=1. ready_i=1 for 1 cycle -> one pop, one new grant the following cycle.
REQ-029 Master gnt random 50%, ready_i random 50%, 1000 loads -> scoreboard order/data match, count never exceeds 4.
REQ-030 clear_i in cycle of a grant with 3 entries buffered -> next cycle r_valid=0, count=0, late response dropped, empty=1.
REQ-031 Slave request with wen=0 -> master req=0, slave gnt=0, wr_err=1 until clear_i pulse, then 0.
